// File: rtl/uart_tx_hakem_if.sv
// uart_tx_hakem_if
//   Bundles the requester-side and transmitter-side handshake of the UART
//   transmit arbiter.
//   Signals:
//     istek_gecerli [N]    per-requester byte valid
//     istek_veri    [8N]   per-requester byte, requester i = [8i+7:8i]
//     istek_son     [N]    byte is the last of its packet
//     istek_hazir   [N]    per-requester accept
//     sahip         [N]    one-hot current owner, 0 when idle
//     ver_veri      [8]    byte to the transmitter
//     ver_gecerli          byte valid to the transmitter
//     uart_hazir           transmitter ready
//     zaman_asimi          one-cycle pulse when an owner is force-released
//   Modports:
//     master : the environment (requesters + transmitter)
//     slave  : the arbiter
`timescale 1ns/1ps
interface uart_tx_hakem_if #(
  parameter int ISTEK_SAYISI = 4
);
  logic [ISTEK_SAYISI-1:0]   istek_gecerli;
  logic [8*ISTEK_SAYISI-1:0] istek_veri;
  logic [ISTEK_SAYISI-1:0]   istek_son;
  logic [ISTEK_SAYISI-1:0]   istek_hazir;
  logic [ISTEK_SAYISI-1:0]   sahip;
  logic [7:0]                ver_veri;
  logic                      ver_gecerli;
  logic                      uart_hazir;
  logic                      zaman_asimi;

  modport master (
    output istek_gecerli, istek_veri, istek_son, uart_hazir,
    input  istek_hazir, sahip, ver_veri, ver_gecerli, zaman_asimi
  );

  modport slave (
    input  istek_gecerli, istek_veri, istek_son, uart_hazir,
    output istek_hazir, sahip, ver_veri, ver_gecerli, zaman_asimi
  );
endinterface

// File: rtl/uart_tx_hakem.sv
// uart_tx_hakem
//   Packet-locked round-robin arbiter that shares one UART transmitter among
//   ISTEK_SAYISI byte-stream requesters. The owner keeps the transmitter until
//   it hands over a byte flagged istek_son; a single-byte holding buffer
//   (tampon) sits between the owner and the transmitter.
//   Ports:
//     clk_g  in   clock
//     rst_g  in   synchronous reset, active-high
//     bus    slave modport of uart_tx_hakem_if (requester and transmitter
//            handshakes, owner vector, timeout pulse)
//   Parameters:
//     ISTEK_SAYISI  number of requesters (>= 2)
//     ZAMAN_ASIMI   idle owner cycles before forced release
//   Optional feature:
//     UART_ARB_TIMEOUT_EN  when defined, an owner that leaves its valid low for
//                          ZAMAN_ASIMI cycles with an empty buffer is released
//                          and zaman_asimi pulses; otherwise zaman_asimi is 0.
`timescale 1ns/1ps
module uart_tx_hakem #(
  parameter int ISTEK_SAYISI = 4,
  parameter int ZAMAN_ASIMI  = 65535
) (
  input  logic           clk_g,
  input  logic           rst_g,
  uart_tx_hakem_if.slave bus
);
  localparam int PTR_W = $clog2(ISTEK_SAYISI);
  localparam logic [PTR_W-1:0] SON_IDX = PTR_W'(ISTEK_SAYISI - 1);

  // Parameter sanity check at elaboration time.
  if (ISTEK_SAYISI < 2 || ZAMAN_ASIMI < 1) begin : g_param_hata
    $error("uart_tx_hakem: ISTEK_SAYISI must be >= 2 and ZAMAN_ASIMI >= 1");
  end

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    SAHIP = 2'd1,
    BITIR = 2'd2
  } durum_e;

  durum_e           durum_q, durum_d;
  logic [PTR_W-1:0] sahip_idx_q, sahip_idx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             tampon_dolu_q, tampon_dolu_d;
  logic [7:0]       tampon_veri_q, tampon_veri_d;

  logic [7:0]       veri_dizi [ISTEK_SAYISI];
  logic             bulundu;
  logic [PTR_W-1:0] secilen;
  logic [PTR_W-1:0] aday;
  logic [PTR_W-1:0] sonraki_ptr;
  logic             kabul;
  logic             cikis;

  // Per-requester byte lanes and owner-decoded outputs.
  for (genvar gi = 0; gi < ISTEK_SAYISI; gi++) begin : g_istek
    assign veri_dizi[gi]       = bus.istek_veri[8*gi +: 8];
    assign bus.sahip[gi]       = (durum_q != BOSTA) && (sahip_idx_q == PTR_W'(gi));
    assign bus.istek_hazir[gi] = (durum_q == SAHIP) && !tampon_dolu_q &&
                                 (sahip_idx_q == PTR_W'(gi));
  end

  assign bus.ver_gecerli = tampon_dolu_q;
  assign bus.ver_veri    = tampon_veri_q;

  // Byte taken from the owner: only while the buffer is empty, so a fill
  // and a drain can never coincide.
  assign kabul = (durum_q == SAHIP) && !tampon_dolu_q && bus.istek_gecerli[sahip_idx_q];
  assign cikis = tampon_dolu_q && bus.uart_hazir;

  assign sonraki_ptr = (sahip_idx_q == SON_IDX) ? '0 : sahip_idx_q + 1'b1;

  // Round-robin search: walk from the pointer with wrap-around and keep the
  // first valid requester encountered.
  always_comb begin
    bulundu = 1'b0;
    secilen = ptr_q;
    aday    = ptr_q;
    for (int k = 0; k < ISTEK_SAYISI; k++) begin
      if (!bulundu && bus.istek_gecerli[aday]) begin
        bulundu = 1'b1;
        secilen = aday;
      end
      aday = (aday == SON_IDX) ? '0 : aday + 1'b1;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(ZAMAN_ASIMI + 1);
  logic [CNT_W-1:0] sayac_q, sayac_d;
  logic             zaman_asimi_q, zaman_asimi_d;
  assign bus.zaman_asimi = zaman_asimi_q;
`else
  assign bus.zaman_asimi = 1'b0;
`endif

  always_comb begin
    durum_d       = durum_q;
    sahip_idx_d   = sahip_idx_q;
    ptr_d         = ptr_q;
    tampon_dolu_d = tampon_dolu_q;
    tampon_veri_d = tampon_veri_q;
`ifdef UART_ARB_TIMEOUT_EN
    zaman_asimi_d = 1'b0;
    sayac_d       = sayac_q;
    if (kabul || durum_q != SAHIP) begin
      sayac_d = '0;
    end
`endif

    if (cikis) begin
      tampon_dolu_d = 1'b0;
    end
    if (kabul) begin
      tampon_dolu_d = 1'b1;
      tampon_veri_d = veri_dizi[sahip_idx_q];
    end

    unique case (durum_q)
      BOSTA: begin
        if (bulundu) begin
          sahip_idx_d = secilen;
          durum_d     = SAHIP;
        end
      end
      SAHIP: begin
        // BITIR itself records that the buffered byte closes the packet.
        if (kabul && bus.istek_son[sahip_idx_q]) begin
          durum_d = BITIR;
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (!tampon_dolu_q && !bus.istek_gecerli[sahip_idx_q]) begin
          if (sayac_q == CNT_W'(ZAMAN_ASIMI - 1)) begin
            durum_d       = BOSTA;
            ptr_d         = sonraki_ptr;
            zaman_asimi_d = 1'b1;
            sayac_d       = '0;
          end else begin
            sayac_d = sayac_q + 1'b1;
          end
        end
`endif
      end
      BITIR: begin
        // Release on the drain of the closing byte; the empty-buffer term
        // only guards against an unreachable stuck state.
        if (cikis || !tampon_dolu_q) begin
          durum_d = BOSTA;
          ptr_d   = sonraki_ptr;
        end
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      durum_q       <= BOSTA;
      sahip_idx_q   <= '0;
      ptr_q         <= '0;
      tampon_dolu_q <= 1'b0;
      tampon_veri_q <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      sayac_q       <= '0;
      zaman_asimi_q <= 1'b0;
`endif
    end else begin
      durum_q       <= durum_d;
      sahip_idx_q   <= sahip_idx_d;
      ptr_q         <= ptr_d;
      tampon_dolu_q <= tampon_dolu_d;
      tampon_veri_q <= tampon_veri_d;
`ifdef UART_ARB_TIMEOUT_EN
      sayac_q       <= sayac_d;
      zaman_asimi_q <= zaman_asimi_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_hakem.sv
`timescale 1ns/1ps
module tb_uart_tx_hakem;
  localparam int N   = 4;
  localparam int TMO = 20;
  localparam int QD  = 512;

  logic clk_g = 1'b0;
  logic rst_g = 1'b1;
  always #5 clk_g = ~clk_g;

  uart_tx_hakem_if #(.ISTEK_SAYISI(N)) bus ();

  uart_tx_hakem #(.ISTEK_SAYISI(N), .ZAMAN_ASIMI(TMO)) dut (
    .clk_g (clk_g),
    .rst_g (rst_g),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Requester byte streams: {first_of_packet, son, data}.
  logic [9:0] req_mem [N][QD];
  int         wr_ptr [N] = '{default: 0};
  int         rd_ptr [N] = '{default: 0};
  bit         gap_en   = 1'b0;
  bit         tx_stall = 1'b0;
  int         exp_ptr  = 0;

  logic [7:0] tx_log [$];
  int         tx_busy = 0;

  // Packet descriptions used by the round-robin reference model.
  logic [7:0] pk_data [N][4][4];
  int         pk_len  [N][4];
  int         pk_cnt  [N];

  // Requester drivers: present the head entry of each stream after the edge.
  logic [9:0] ent;
  always @(posedge clk_g) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (rd_ptr[i] != wr_ptr[i]) begin
        ent = req_mem[i][rd_ptr[i] % QD];
        bus.istek_veri[8*i +: 8] = ent[7:0];
        bus.istek_son[i]         = ent[8];
        bus.istek_gecerli[i]     = ent[9] || !gap_en || ($urandom_range(3, 0) != 0);
      end else begin
        bus.istek_veri[8*i +: 8] = 8'h00;
        bus.istek_son[i]         = 1'b0;
        bus.istek_gecerli[i]     = 1'b0;
      end
    end
  end

  // Transmitter model and requester-side consumption, evaluated on the
  // falling edge with the values the next rising edge will see.
  always @(negedge clk_g) begin
    if (rst_g) begin
      tx_busy = 0;
      bus.uart_hazir = 1'b0;
      for (int i = 0; i < N; i++) rd_ptr[i] = wr_ptr[i];
    end else begin
      for (int i = 0; i < N; i++)
        if (bus.istek_gecerli[i] === 1'b1 && bus.istek_hazir[i] === 1'b1) rd_ptr[i]++;
      if (tx_busy > 0) tx_busy--;
      bus.uart_hazir = !tx_stall && (tx_busy == 0);
      if (bus.uart_hazir && bus.ver_gecerli === 1'b1) begin
        tx_log.push_back(bus.ver_veri);
        tx_busy = $urandom_range(4, 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk_g);
    #3;
  endtask

  task automatic push(input int r, input bit first, input bit son, input logic [7:0] d);
    req_mem[r][wr_ptr[r] % QD] = {first, son, d};
    wr_ptr[r]++;
  endtask

  function automatic bit streams_empty();
    for (int i = 0; i < N; i++) if (rd_ptr[i] != wr_ptr[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle with protocol checks: byte-to-valid latency, held output
  // stability, and grant sanity.
  task automatic cyc();
    logic       vg;
    logic [7:0] vv;
    int         ls;
    bit         tk;
    logic [7:0] tbyte;
    bit         in_rst;
    vg = bus.ver_gecerli; vv = bus.ver_veri; ls = tx_log.size(); in_rst = rst_g;
    tk = 1'b0; tbyte = 8'h00;
    for (int i = 0; i < N; i++)
      if (bus.istek_gecerli[i] === 1'b1 && bus.istek_hazir[i] === 1'b1) begin
        tk = 1'b1; tbyte = bus.istek_veri[8*i +: 8];
      end
    tick();
    if (!in_rst) begin
      if (tk) begin
        n_checks++;
        if (bus.ver_gecerli !== 1'b1 || bus.ver_veri !== tbyte) begin
          n_fail++;
          $display("FAIL latency: ver_gecerli=%b ver_veri=%h, required 1 / %h", bus.ver_gecerli, bus.ver_veri, tbyte);
        end
      end else if (vg === 1'b1 && tx_log.size() == ls) begin
        n_checks++;
        if (bus.ver_gecerli !== 1'b1 || bus.ver_veri !== vv) begin
          n_fail++;
          $display("FAIL hold: ver_gecerli=%b ver_veri=%h, required 1 / %h", bus.ver_gecerli, bus.ver_veri, vv);
        end
      end
      n_checks++;
      if (!$onehot0(bus.sahip) || (bus.istek_hazir & ~bus.sahip) != '0 ||
          (bus.ver_gecerli === 1'b1 && bus.istek_hazir != '0)) begin
        n_fail++;
        $display("FAIL grant: sahip=%b istek_hazir=%b ver_gecerli=%b", bus.sahip, bus.istek_hazir, bus.ver_gecerli);
      end
    end
  endtask

  task automatic do_reset();
    rst_g = 1'b1;
    tick(); tick();
    rst_g = 1'b0;
    exp_ptr = 0; gap_en = 1'b0; tx_stall = 1'b0;
  endtask

  task automatic wait_log(input string nm, input int target, input int budget);
    int c;
    for (c = 0; c < budget && tx_log.size() < target; c++) cyc();
    n_checks++;
    if (tx_log.size() < target) begin
      n_fail++;
      $display("FAIL %s: tx bytes=%0d, required %0d within %0d cycles", nm, tx_log.size(), target, budget);
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int c;
    bit done;
    done = 1'b0;
    for (c = 0; c < budget && !done; c++) begin
      cyc();
      done = streams_empty() && bus.sahip == '0 && bus.ver_gecerli === 1'b0;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: not idle after %0d cycles (sahip=%b ver_gecerli=%b)", nm, budget, bus.sahip, bus.ver_gecerli);
    end
  endtask

  task automatic check_byte(input string nm, input int pos, input logic [7:0] want);
    n_checks++;
    if (pos >= tx_log.size()) begin
      n_fail++;
      $display("FAIL %s: tx byte %0d missing, required %h", nm, pos, want);
    end else if (tx_log[pos] !== want) begin
      n_fail++;
      $display("FAIL %s: tx byte %0d = %h, required %h", nm, pos, tx_log[pos], want);
    end
  endtask

  // Loads pk_* into the streams, predicts the TX order at packet level
  // (round-robin from exp_ptr, whole packets), runs and compares.
  task automatic run_batch(input string nm, output logic [N-1:0] first_sahip, output int base);
    logic [7:0] expq [$];
    int served [N];
    int p, idx, remaining;
    remaining = 0;
    for (int i = 0; i < N; i++) begin
      served[i] = 0;
      remaining += pk_cnt[i];
      for (int k = 0; k < pk_cnt[i]; k++)
        for (int j = 0; j < pk_len[i][k]; j++)
          push(i, j == 0, j == pk_len[i][k] - 1, pk_data[i][k][j]);
    end
    p = exp_ptr;
    while (remaining > 0) begin
      idx = -1;
      for (int k = 0; k < N; k++)
        if (idx < 0 && served[(p + k) % N] < pk_cnt[(p + k) % N]) idx = (p + k) % N;
      for (int j = 0; j < pk_len[idx][served[idx]]; j++) expq.push_back(pk_data[idx][served[idx]][j]);
      served[idx]++;
      remaining--;
      p = (idx + 1) % N;
    end
    exp_ptr = p;
    base = tx_log.size();
    first_sahip = '0;
    begin
      int c;
      bit done;
      done = 1'b0;
      for (c = 0; c < 3000 && !done; c++) begin
        cyc();
        if (first_sahip == '0) first_sahip = bus.sahip;
        done = streams_empty() && bus.sahip == '0 && bus.ver_gecerli === 1'b0;
      end
      n_checks++;
      if (!done) begin
        n_fail++;
        $display("FAIL %s_timeout: batch not finished, sahip=%b", nm, bus.sahip);
      end
    end
    n_checks++;
    if (tx_log.size() - base != expq.size()) begin
      n_fail++;
      $display("FAIL %s_count: tx bytes=%0d, required %0d", nm, tx_log.size() - base, expq.size());
    end
    for (int j = 0; j < expq.size(); j++) check_byte(nm, base + j, expq[j]);
    $display("batch %s: %0d bytes expected, %0d seen", nm, expq.size(), tx_log.size() - base);
  endtask

  task automatic clear_pk();
    for (int i = 0; i < N; i++) pk_cnt[i] = 0;
  endtask

  task automatic test_reset();
    rst_g = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if ({bus.sahip, bus.istek_hazir, bus.ver_gecerli, bus.ver_veri, bus.zaman_asimi} !== '0) begin
      n_fail++;
      $display("FAIL reset: sahip=%b hazir=%b ver_gecerli=%b ver_veri=%h zaman_asimi=%b, required all 0",
               bus.sahip, bus.istek_hazir, bus.ver_gecerli, bus.ver_veri, bus.zaman_asimi);
    end
    rst_g = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_packet();
    logic [N-1:0] fs;
    int base;
    do_reset();
    clear_pk();
    pk_cnt[0] = 1; pk_len[0][0] = 3;
    pk_data[0][0][0] = 8'h41; pk_data[0][0][1] = 8'h42; pk_data[0][0][2] = 8'h43;
    run_batch("single", fs, base);
    n_checks++;
    if (fs !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_owner: sahip=%b, required 0001", fs);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] fs;
    int base;
    do_reset();
    clear_pk();
    for (int i = 0; i < N; i++) begin
      pk_cnt[i] = 1; pk_len[i][0] = 1; pk_data[i][0][0] = 8'h10 + 8'(i);
    end
    run_batch("rr_first", fs, base);
    check_byte("rr_order", base, 8'h10);
    check_byte("rr_order", base + 3, 8'h13);
    for (int i = 0; i < N; i++) pk_data[i][0][0] = 8'h20 + 8'(i);
    run_batch("rr_wrap", fs, base);
    check_byte("rr_wrap_first", base, 8'h20);
  endtask

  task automatic test_packet_lock();
    int base;
    do_reset();
    base = tx_log.size();
    push(1, 1'b1, 1'b0, 8'hA0);
    wait_log("lock_a0", base + 1, 50);
    push(2, 1'b1, 1'b1, 8'hB0);
    repeat (30) cyc();
    n_checks++;
    if (tx_log.size() != base + 1 || bus.sahip !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_hold: tx bytes=%0d sahip=%b, required %0d / 0010", tx_log.size() - base, bus.sahip, 1);
    end
    push(1, 1'b0, 1'b1, 8'hA1);
    wait_idle("lock_idle", 200);
    check_byte("lock_order", base, 8'hA0);
    check_byte("lock_order", base + 1, 8'hA1);
    check_byte("lock_order", base + 2, 8'hB0);
  endtask

  task automatic test_stall();
    int  base;
    bit  ok;
    do_reset();
    base = tx_log.size();
    tx_stall = 1'b1;
    push(0, 1'b1, 1'b0, 8'h77);
    push(0, 1'b0, 1'b1, 8'h78);
    for (int c = 0; c < 20 && bus.ver_gecerli !== 1'b1; c++) cyc();
    ok = 1'b1;
    for (int c = 0; c < 200; c++) begin
      cyc();
      if (bus.ver_gecerli !== 1'b1 || bus.ver_veri !== 8'h77 || bus.istek_hazir !== 4'b0000) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall: ver_gecerli=%b ver_veri=%h istek_hazir=%b, required 1 / 77 / 0000 throughout",
               bus.ver_gecerli, bus.ver_veri, bus.istek_hazir);
    end
    tx_stall = 1'b0;
    wait_idle("stall_idle", 200);
    check_byte("stall_order", base, 8'h77);
    check_byte("stall_order", base + 1, 8'h78);
  endtask

  task automatic test_reset_mid_packet();
    int base;
    do_reset();
    base = tx_log.size();
    tx_stall = 1'b1;
    push(2, 1'b1, 1'b1, 8'h99);
    for (int c = 0; c < 20 && bus.ver_gecerli !== 1'b1; c++) cyc();
    rst_g = 1'b1;
    tick();
    n_checks++;
    if ({bus.sahip, bus.istek_hazir, bus.ver_gecerli, bus.ver_veri, bus.zaman_asimi} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: sahip=%b hazir=%b ver_gecerli=%b ver_veri=%h, required all 0",
               bus.sahip, bus.istek_hazir, bus.ver_gecerli, bus.ver_veri);
    end
    rst_g = 1'b0;
    tx_stall = 1'b0;
    repeat (20) cyc();
    n_checks++;
    if (tx_log.size() != base) begin
      n_fail++;
      $display("FAIL reset_mid_tx: tx bytes=%0d, required 0", tx_log.size() - base);
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int base, pulses;
    bit released;
    do_reset();
    base = tx_log.size();
    push(0, 1'b1, 1'b0, 8'h55);
    push(1, 1'b1, 1'b1, 8'h66);
    wait_log("tmo_55", base + 1, 50);
    pulses = 0; released = 1'b1;
    for (int c = 0; c < 3 * TMO; c++) begin
      cyc();
      if (bus.zaman_asimi === 1'b1) begin
        pulses++;
        if (bus.sahip !== 4'b0000) released = 1'b0;
      end
    end
    n_checks++;
    if (pulses != 1 || !released) begin
      n_fail++;
      $display("FAIL timeout_pulse: pulse cycles=%0d released=%0d, required 1 / 1", pulses, released);
    end
    wait_idle("tmo_idle", 200);
    check_byte("tmo_order", base, 8'h55);
    check_byte("tmo_order", base + 1, 8'h66);
  endtask
`else
  task automatic test_no_timeout();
    int base;
    bit pulse_seen;
    do_reset();
    base = tx_log.size();
    push(0, 1'b1, 1'b0, 8'h55);
    push(1, 1'b1, 1'b1, 8'h66);
    wait_log("hold_55", base + 1, 50);
    pulse_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (bus.zaman_asimi !== 1'b0) pulse_seen = 1'b1;
    end
    n_checks++;
    if (bus.sahip !== 4'b0001 || tx_log.size() != base + 1 || pulse_seen) begin
      n_fail++;
      $display("FAIL owner_hold: sahip=%b tx bytes=%0d pulse=%0d, required 0001 / 1 / 0",
               bus.sahip, tx_log.size() - base, pulse_seen);
    end
    push(0, 1'b0, 1'b1, 8'h56);
    wait_idle("hold_idle", 200);
    check_byte("hold_order", base, 8'h55);
    check_byte("hold_order", base + 1, 8'h56);
    check_byte("hold_order", base + 2, 8'h66);
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] fs;
    int base;
    do_reset();
    gap_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      clear_pk();
      for (int i = 0; i < N; i++) begin
        pk_cnt[i] = $urandom_range(2, 0);
        for (int k = 0; k < pk_cnt[i]; k++) begin
          pk_len[i][k] = $urandom_range(4, 1);
          for (int j = 0; j < 4; j++) pk_data[i][k][j] = 8'($urandom);
        end
      end
      if (pk_cnt[0] + pk_cnt[1] + pk_cnt[2] + pk_cnt[3] == 0) begin
        pk_cnt[0] = 1; pk_len[0][0] = 1; pk_data[0][0][0] = 8'($urandom);
      end
      run_batch($sformatf("random%0d", it), fs, base);
    end
    gap_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_packet_lock();
    test_stall();
    test_reset_mid_packet();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
